// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: drives a req/ack data-memory port, builds byte lanes,
// extends load data and registers the MEM/WB payload, stalling upstream while an access is open.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [31:0] pc_plus_4_in,
  input  logic [2:0]  fun3_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        jump_in,
  input  logic [4:0]  write_reg_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_reg_write_out,
  output logic [4:0]  wb_write_reg_out,
  output logic [31:0] wb_data_out,
  output logic        mem_err,
  output logic [1:0]  mem_err_cause
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] k);
    case (size)
      2'b00:   return 4'b0001 << k;
      2'b01:   return 4'b0011 << k;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] k,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{k, 3'b000} +: 8];
    h = k[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rdata;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          wb_rw_q, wb_rw_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          err_q, err_d;
  logic [1:0]    cause_q, cause_d;

  logic mem_op, illegal, misaligned;

  always_comb begin
    mem_op     = mem_write_in | mem_to_reg_in;
    illegal    = mem_op && (fun3_in == 3'b011 || fun3_in == 3'b110 || fun3_in == 3'b111);
    misaligned = mem_op && ((fun3_in[1:0] == 2'b01 && alu_result_in[0]) ||
                            (fun3_in[1:0] == 2'b10 && alu_result_in[1:0] != 2'b00));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    wb_rw_d   = wb_rw_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    err_d     = 1'b0;
    cause_d   = cause_q;
    stall_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          wb_rw_d   = reg_write_in;
          wb_rd_d   = write_reg_in;
          wb_data_d = jump_in ? pc_plus_4_in : alu_result_in;
        end else if (illegal || misaligned) begin
          err_d   = 1'b1;
          cause_d = illegal ? 2'b11 : 2'b01;
          wb_rw_d = 1'b0;
        end else begin
          stall_out = 1'b1;
          state_d   = BUSY;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = mem_write_in;
          addr_d    = {alu_result_in[31:2], 2'b00};
          be_d      = store_be(fun3_in[1:0], alu_result_in[1:0]);
          wdata_d   = store_wdata(fun3_in[1:0], write_data_in);
          wb_rw_d   = 1'b0;
        end
      end
      BUSY: begin
        // EX/MEM is held while we stall, so the *_in fields still describe this access
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (we_q) begin
            wb_rw_d = 1'b0;
          end else begin
            wb_rw_d   = reg_write_in;
            wb_rd_d   = write_reg_in;
            wb_data_d = load_extend(fun3_in, alu_result_in[1:0], dmem_rdata);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          cause_d = 2'b10;
          wb_rw_d = 1'b0;
        end else begin
          stall_out = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          wb_rw_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      wb_rw_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      wb_rw_q   <= wb_rw_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
      cause_q   <= cause_d;
    end
  end

  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_be          = be_q;
  assign wb_reg_write_out = wb_rw_q;
  assign wb_write_reg_out = wb_rd_q;
  assign wb_data_out      = wb_data_q;
  assign mem_err          = err_q;
  assign mem_err_cause    = cause_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus randomized ops checked against a byte-level model.
module tb_mem_stage_lsu;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_in, write_data_in, pc_plus_4_in;
  logic [2:0]  fun3_in;
  logic        mem_write_in, mem_to_reg_in, reg_write_in, jump_in;
  logic [4:0]  write_reg_in;
  logic        stall_out, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_reg_write_out, mem_err;
  logic [4:0]  wb_write_reg_out;
  logic [31:0] wb_data_out;
  logic [1:0]  mem_err_cause;

  int checks = 0;
  int failures = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in), .pc_plus_4_in(pc_plus_4_in),
    .fun3_in(fun3_in), .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .jump_in(jump_in), .write_reg_in(write_reg_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_reg_write_out(wb_reg_write_out), .wb_write_reg_out(wb_write_reg_out),
    .wb_data_out(wb_data_out), .mem_err(mem_err), .mem_err_cause(mem_err_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  stalls;
    logic [7:0]  bstalls;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;
    logic [1:0]  cause;
    logic        stable;
    logic        hung;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_mask(input int n);
    return (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    int n = ref_size(f3);
    int off = (n == 4) ? 0 : int'(addr % 4);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n = ref_size(f3);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4 / n; i++) r = r | ((wd & ref_mask(n)) << (8 * n * i));
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int n = ref_size(f3);
    logic [31:0] v = (rdata >> (8 * int'(addr % 4))) & ref_mask(n);
    if (n < 4 && f3[2] == 1'b0 && v[8 * n - 1]) v = v | ~ref_mask(n);
    return v;
  endfunction

  function automatic logic [1:0] ref_cause(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 2'b11;
    if (addr % ref_size(f3) != 0) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    alu_result_in = 0; write_data_in = 0; pc_plus_4_in = 0; fun3_in = 0;
    mem_write_in = 0; mem_to_reg_in = 0; reg_write_in = 0; jump_in = 0;
    write_reg_in = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] addr, wd, input logic mw, mr,
                          rw, jmp, input logic [4:0] rd, input logic [31:0] pc4);
    fun3_in = f3; alu_result_in = addr; write_data_in = wd; mem_write_in = mw;
    mem_to_reg_in = mr; reg_write_in = rw; jump_in = jmp; write_reg_in = rd; pc_plus_4_in = pc4;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Runs one memory op with an ack on BUSY cycle ack_cycle (0 = never); returns observations.
  task automatic do_mem(input logic [2:0] f3, input logic [31:0] addr, wd, input logic st, rw,
                        input logic [4:0] rd, input int ack_cycle, input logic [31:0] rdata,
                        output obs_t o);
    o = '0;
    o.stable = 1'b1;
    drive_op(f3, addr, wd, st, !st, rw, 1'b0, rd, 32'h0);
    #1;
    if (stall_out) o.stalls++;
    @(posedge clk); #1;
    o.req = dmem_req; o.we = dmem_we; o.be = dmem_be; o.addr = dmem_addr; o.wdata = dmem_wdata;
    if (dmem_req) begin
      o.hung = 1'b1;
      for (int c = 1; c <= TO + 4; c++) begin
        dmem_ack = (c == ack_cycle);
        dmem_rdata = rdata;
        #1;
        if (dmem_req !== 1'b1 || dmem_be !== o.be || dmem_addr !== o.addr ||
            dmem_wdata !== o.wdata || dmem_we !== o.we) o.stable = 1'b0;
        if (stall_out === 1'b0) begin
          @(posedge clk); #1;
          dmem_ack = 1'b0;
          o.hung = 1'b0;
          break;
        end
        o.stalls++;
        o.bstalls++;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
      end
    end
    o.wb_rw = wb_reg_write_out; o.wb_rd = wb_write_reg_out; o.wb_data = wb_data_out;
    o.err = mem_err; o.cause = mem_err_cause;
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", dmem_req); end
    checks++; if (wb_reg_write_out !== 1'b0 || wb_data_out !== 32'h0 || wb_write_reg_out !== 5'h0) begin
      failures++; $display("FAIL reset_wb got=%0b/%0d/%h exp=0", wb_reg_write_out, wb_write_reg_out, wb_data_out); end
    checks++; if (mem_err !== 1'b0 || mem_err_cause !== 2'b00) begin
      failures++; $display("FAIL reset_err got=%0b/%0b exp=0/00", mem_err, mem_err_cause); end
    checks++; if (dmem_be !== 4'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_we !== 1'b0) begin
      failures++; $display("FAIL reset_port got be=%h addr=%h wd=%h we=%b exp=0", dmem_be, dmem_addr, dmem_wdata, dmem_we); end
    reset = 1'b0;
  endtask

  task automatic test_reset_busy();
    drive_op(3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0);
    step();
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin
      failures++; $display("FAIL rstbusy_issue got req=%b addr=%h exp=1/00000100", dmem_req, dmem_addr); end
    step();
    step();
    reset = 1'b1;
    step();
    idle_inputs();
    checks++; if (dmem_req !== 1'b0 || wb_reg_write_out !== 1'b0 || mem_err !== 1'b0) begin
      failures++; $display("FAIL rstbusy_clear got req=%b wb=%b err=%b exp=0/0/0", dmem_req, wb_reg_write_out, mem_err); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_load_byte();
    obs_t o;
    do_mem(3'b000, 32'h1003, 32'h0, 1'b0, 1'b1, 5'd9, 3, 32'h80FF_FF00, o);
    checks++; if (o.wb_data !== 32'hFFFF_FF80 || o.wb_rw !== 1'b1 || o.wb_rd !== 5'd9) begin
      failures++; $display("FAIL lb_wb got=%b/%0d/%h exp=1/9/ffffff80", o.wb_rw, o.wb_rd, o.wb_data); end
    checks++; if (o.stalls !== 8'd3) begin failures++; $display("FAIL lb_stalls got=%0d exp=3", o.stalls); end
    checks++; if (o.addr !== 32'h1000 || o.we !== 1'b0 || !o.stable) begin
      failures++; $display("FAIL lb_req got addr=%h we=%b stable=%b exp=00001000/0/1", o.addr, o.we, o.stable); end
  endtask

  task automatic test_store_half();
    obs_t o;
    do_mem(3'b001, 32'h2002, 32'h0000_ABCD, 1'b1, 1'b0, 5'd3, 1, 32'h0, o);
    checks++; if (o.be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", o.be); end
    checks++; if (o.wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", o.wdata); end
    checks++; if (o.addr !== 32'h2000 || o.we !== 1'b1) begin
      failures++; $display("FAIL sh_addr got=%h we=%b exp=00002000/1", o.addr, o.we); end
    checks++; if (o.wb_rw !== 1'b0 || o.stalls !== 8'd1 || o.err !== 1'b0) begin
      failures++; $display("FAIL sh_done got wb=%b stalls=%0d err=%b exp=0/1/0", o.wb_rw, o.stalls, o.err); end
  endtask

  task automatic test_errors();
    obs_t o;
    do_mem(3'b010, 32'h3001, 32'h0, 1'b0, 1'b1, 5'd4, 1, 32'h0, o);
    checks++; if (o.req !== 1'b0 || o.stalls !== 8'd0) begin
      failures++; $display("FAIL mis_noreq got req=%b stalls=%0d exp=0/0", o.req, o.stalls); end
    checks++; if (o.err !== 1'b1 || o.cause !== 2'b01 || o.wb_rw !== 1'b0) begin
      failures++; $display("FAIL mis_err got err=%b cause=%b wb=%b exp=1/01/0", o.err, o.cause, o.wb_rw); end
    step();
    checks++; if (mem_err !== 1'b0 || mem_err_cause !== 2'b01) begin
      failures++; $display("FAIL mis_pulse got err=%b cause=%b exp=0/01", mem_err, mem_err_cause); end
    do_mem(3'b011, 32'h3001, 32'h0, 1'b0, 1'b1, 5'd4, 1, 32'h0, o);
    checks++; if (o.err !== 1'b1 || o.cause !== 2'b11 || o.req !== 1'b0) begin
      failures++; $display("FAIL ill_err got err=%b cause=%b req=%b exp=1/11/0", o.err, o.cause, o.req); end
  endtask

  task automatic test_timeout();
    obs_t o;
    do_mem(3'b101, 32'h4000, 32'h0, 1'b0, 1'b1, 5'd6, 0, 32'h0, o);
    checks++; if (o.bstalls !== 8'(TO - 1) || o.hung) begin
      failures++; $display("FAIL to_stalls got=%0d hung=%b exp=%0d/0", o.bstalls, o.hung, TO - 1); end
    checks++; if (o.err !== 1'b1 || o.cause !== 2'b10 || o.wb_rw !== 1'b0) begin
      failures++; $display("FAIL to_err got err=%b cause=%b wb=%b exp=1/10/0", o.err, o.cause, o.wb_rw); end
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL to_req got=%b exp=0", dmem_req); end
    drive_op(3'b000, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0000_0088);
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL add_stall got=%b exp=0", stall_out); end
    step();
    checks++; if (wb_reg_write_out !== 1'b1 || wb_write_reg_out !== 5'd7 || wb_data_out !== 32'h1234) begin
      failures++; $display("FAIL add_wb got=%b/%0d/%h exp=1/7/00001234", wb_reg_write_out, wb_write_reg_out, wb_data_out); end
    drive_op(3'b000, 32'hDEAD_0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h0000_0088);
    step();
    checks++; if (wb_reg_write_out !== 1'b1 || wb_write_reg_out !== 5'd1 || wb_data_out !== 32'h88) begin
      failures++; $display("FAIL jal_wb got=%b/%0d/%h exp=1/1/00000088", wb_reg_write_out, wb_write_reg_out, wb_data_out); end
    idle_inputs();
    step();
  endtask

  task automatic test_ack_on_timeout();
    obs_t o;
    do_mem(3'b010, 32'h5004, 32'h0, 1'b0, 1'b1, 5'd12, TO, 32'h1357_9BDF, o);
    checks++; if (o.err !== 1'b0 || o.wb_rw !== 1'b1 || o.wb_data !== 32'h1357_9BDF) begin
      failures++; $display("FAIL lastack got err=%b wb=%b data=%h exp=0/1/13579bdf", o.err, o.wb_rw, o.wb_data); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 2);
      logic [2:0] f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      logic [31:0] addr = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rdata = $urandom;
      logic [4:0] rd = 5'($urandom);
      logic rw = 1'($urandom);
      int ack = $urandom_range(1, TO);
      if (kind == 0) begin
        logic jmp = 1'($urandom);
        logic [31:0] pc4 = $urandom;
        drive_op(f3, addr, wd, 1'b0, 1'b0, rw, jmp, rd, pc4);
        #1;
        checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL rnd_alu_stall i=%0d got=%b exp=0", i, stall_out); end
        step();
        checks++; if (wb_reg_write_out !== rw || wb_write_reg_out !== rd || wb_data_out !== (jmp ? pc4 : addr)) begin
          failures++; $display("FAIL rnd_alu_wb i=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, wb_reg_write_out,
                               wb_write_reg_out, wb_data_out, rw, rd, jmp ? pc4 : addr); end
        idle_inputs();
      end else begin
        logic st = (kind == 2);
        logic [1:0] cause = ref_cause(f3, addr);
        do_mem(f3, addr, wd, st, rw, rd, ack, rdata, o);
        if (cause != 2'b00) begin
          checks++; if (o.req !== 1'b0 || o.err !== 1'b1 || o.cause !== cause || o.wb_rw !== 1'b0) begin
            failures++; $display("FAIL rnd_err i=%0d got req=%b err=%b cause=%b wb=%b exp=0/1/%b/0",
                                 i, o.req, o.err, o.cause, o.wb_rw, cause); end
        end else begin
          checks++; if (o.req !== 1'b1 || o.addr !== {addr[31:2], 2'b00} || o.be !== ref_be(f3, addr) || o.we !== st) begin
            failures++; $display("FAIL rnd_req i=%0d got req=%b addr=%h be=%b we=%b exp=1/%h/%b/%b",
                                 i, o.req, o.addr, o.be, o.we, {addr[31:2], 2'b00}, ref_be(f3, addr), st); end
          checks++; if (o.stalls !== 8'(ack) || !o.stable || o.hung || o.err !== 1'b0) begin
            failures++; $display("FAIL rnd_hs i=%0d got stalls=%0d stable=%b hung=%b err=%b exp=%0d/1/0/0",
                                 i, o.stalls, o.stable, o.hung, o.err, ack); end
          if (st) begin
            checks++; if (o.wdata !== ref_wdata(f3, wd) || o.wb_rw !== 1'b0) begin
              failures++; $display("FAIL rnd_st i=%0d got wd=%h wb=%b exp=%h/0", i, o.wdata, o.wb_rw, ref_wdata(f3, wd)); end
          end else begin
            checks++; if (o.wb_rw !== rw || o.wb_rd !== rd || o.wb_data !== ref_load(f3, addr, rdata)) begin
              failures++; $display("FAIL rnd_ld i=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, o.wb_rw, o.wb_rd,
                                   o.wb_data, rw, rd, ref_load(f3, addr, rdata)); end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_busy();
    test_load_byte();
    test_store_half();
    test_errors();
    test_timeout();
    test_ack_on_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
